// File: rtl/csr_update_tx_pkg.sv
// rtl/csr_update_tx_pkg.sv - shared types and constants for the CSR update transmitter
// Purpose: record layout {id, value}, field widths and the reserved privilege id.
// Ports: none (package).
package csr_update_tx_pkg;

  localparam int ID_W   = 12;
  localparam int DATA_W = 64;
  localparam int REC_W  = ID_W + DATA_W;  // 76

  localparam logic [ID_W-1:0] PRIV_ID = 12'hFFF;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] value;
  } csr_rec_t;

  // Privilege record: reserved id, privilege level zero-extended into the value.
  function automatic csr_rec_t make_priv_rec(input logic [1:0] priv);
    csr_rec_t r;
    r.id    = PRIV_ID;
    r.value = {{(DATA_W-2){1'b0}}, priv};
    return r;
  endfunction

endpackage

// File: rtl/csr_rec_fifo.sv
// rtl/csr_rec_fifo.sv - circular record buffer, 0..3 enqueues and 1 dequeue per cycle
// Purpose: stores csr_rec_t records in order; pointers carry one extra wrap bit.
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   push_cnt               number of records to enqueue this cycle (0..3)
//   push_rec0..2           records in enqueue order; only the first push_cnt are used
//   pop                    dequeue head (ignored when empty)
//   head                   record at the read pointer
//   level                  occupied entries (0..DEPTH)
module csr_rec_fifo
  import csr_update_tx_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  push_cnt,
  input  csr_rec_t    push_rec0,
  input  csr_rec_t    push_rec1,
  input  csr_rec_t    push_rec2,
  input  logic        pop,
  output csr_rec_t    head,
  output logic [AW:0] level
);

  csr_rec_t      mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] wa0, wa1, wa2;
  logic          do_pop;

  // Slot addresses wrap naturally in AW bits.
  assign wa0 = wr_ptr[AW-1:0];
  assign wa1 = wr_ptr[AW-1:0] + AW'(1);
  assign wa2 = wr_ptr[AW-1:0] + AW'(2);

  assign level  = wr_ptr - rd_ptr;
  assign do_pop = pop && (level != '0);
  assign head   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_cnt >= 2'd1) mem[wa0] <= push_rec0;
      if (push_cnt >= 2'd2) mem[wa1] <= push_rec1;
      if (push_cnt == 2'd3) mem[wa2] <= push_rec2;
      wr_ptr <= wr_ptr + (AW+1)'(push_cnt);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/csr_update_tx.sv
// rtl/csr_update_tx.sv - commit-side CSR/privilege update stream transmitter
// Purpose: packs up to two CSR writes and one privilege change per accepted bundle
//   into {id, value} records, buffers them, and emits one record per cycle.
// Optional feature: CSR_UPDATE_DEDUP_EN - same-id write pair keeps only the younger write.
// Ports:
//   clock, reset                     rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready              commit bundle handshake
//   in_wen0, in_id0, in_val0         older CSR write
//   in_wen1, in_id1, in_val1         younger CSR write
//   in_priv_wen, in_priv             privilege change (youngest)
//   out_valid / out_ready / out_rec  record stream {id[11:0], value[63:0]}
//   out_level                        occupied FIFO entries
module csr_update_tx
  import csr_update_tx_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen0,
  input  logic [ID_W-1:0]   in_id0,
  input  logic [DATA_W-1:0] in_val0,
  input  logic              in_wen1,
  input  logic [ID_W-1:0]   in_id1,
  input  logic [DATA_W-1:0] in_val1,
  input  logic              in_priv_wen,
  input  logic [1:0]        in_priv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REC_W-1:0]  out_rec,
  output logic [LW-1:0]     out_level
);

  csr_rec_t   rec0, rec1, rec_priv;
  csr_rec_t   push_rec0, push_rec1, push_rec2;
  csr_rec_t   head;
  logic       dup;
  logic       keep0;
  logic [1:0] n_rec;
  logic [1:0] push_cnt;
  logic       accept;

  assign rec0     = '{id: in_id0, value: in_val0};
  assign rec1     = '{id: in_id1, value: in_val1};
  assign rec_priv = make_priv_rec(in_priv);

`ifdef CSR_UPDATE_DEDUP_EN
  assign dup = in_wen0 && in_wen1 && (in_id0 == in_id1);
`else
  assign dup = 1'b0;
`endif

  // A dropped slot0 lets the younger records slide down; unused positions
  // beyond n_rec are don't-care to the FIFO.
  assign keep0 = in_wen0 && !dup;
  assign n_rec = {1'b0, keep0} + {1'b0, in_wen1} + {1'b0, in_priv_wen};

  always_comb begin
    push_rec0 = rec_priv;
    push_rec1 = rec_priv;
    push_rec2 = rec_priv;
    if (keep0) begin
      push_rec0 = rec0;
      if (in_wen1) push_rec1 = rec1;
    end else if (in_wen1) begin
      push_rec0 = rec1;
    end
  end

  // Room for a worst-case bundle; derived from stored level only.
  assign in_ready = (out_level <= LW'(DEPTH - 3));
  assign accept   = in_valid && in_ready;
  assign push_cnt = accept ? n_rec : 2'd0;

  csr_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_cnt  (push_cnt),
    .push_rec0 (push_rec0),
    .push_rec1 (push_rec1),
    .push_rec2 (push_rec2),
    .pop       (out_ready),
    .head      (head),
    .level     (out_level)
  );

  assign out_valid = (out_level != '0);
  assign out_rec   = head;

endmodule

// File: tb/tb_csr_update_tx.sv
// tb/tb_csr_update_tx.sv - directed self-checking bench for csr_update_tx
module tb_csr_update_tx;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wen0 = 1'b0;
  logic [11:0] in_id0 = '0;
  logic [63:0] in_val0 = '0;
  logic        in_wen1 = 1'b0;
  logic [11:0] in_id1 = '0;
  logic [63:0] in_val1 = '0;
  logic        in_priv_wen = 1'b0;
  logic [1:0]  in_priv = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [75:0] out_rec;
  logic [3:0]  out_level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [75:0] exp_q[$];
  logic [75:0] junk;

  csr_update_tx #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_wen0     (in_wen0),
    .in_id0      (in_id0),
    .in_val0     (in_val0),
    .in_wen1     (in_wen1),
    .in_id1      (in_id1),
    .in_val1     (in_val1),
    .in_priv_wen (in_priv_wen),
    .in_priv     (in_priv),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rec     (out_rec),
    .out_level   (out_level)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [75:0] got, input logic [75:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one bundle, wait (bounded) for acceptance, record the expected records.
  task automatic send(input logic w0, input logic [11:0] i0, input logic [63:0] v0,
                      input logic w1, input logic [11:0] i1, input logic [63:0] v1,
                      input logic pw, input logic [1:0] pv);
    int t;
    logic d;
    in_wen0 = w0; in_id0 = i0; in_val0 = v0;
    in_wen1 = w1; in_id1 = i1; in_val1 = v1;
    in_priv_wen = pw; in_priv = pv;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    if (!in_ready) check("send_timeout", 76'(in_ready), 76'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
`ifdef CSR_UPDATE_DEDUP_EN
    d = w0 && w1 && (i0 == i1);
`else
    d = 1'b0;
`endif
    if (w0 && !d) exp_q.push_back({i0, v0});
    if (w1) exp_q.push_back({i1, v1});
    if (pw) exp_q.push_back({12'hFFF, 62'b0, pv});
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      if (out_valid) begin
        check(tag, out_rec, exp_q[0]);
        junk = exp_q.pop_front();
      end
      @(posedge clock); #1;
    end
    check({tag, "_left"}, 76'(exp_q.size()), 76'd0);
    check({tag, "_level0"}, 76'(out_level), 76'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int  sent;
    logic acc, pop_now, stall;
    logic [75:0] held;

    // Reset state
    #22 reset = 1'b0;
    @(posedge clock); #1;
    check("rst_valid", 76'(out_valid), 76'd0);
    check("rst_level", 76'(out_level), 76'd0);
    check("rst_ready", 76'(in_ready), 76'd1);
    check("rst_rec",   out_rec, 76'd0);

    // Single record latency
    send(1'b1, 12'h300, 64'hA, 1'b0, 12'h0, 64'h0, 1'b0, 2'd0);
    check("single_rec",   out_rec, {12'h300, 64'hA});
    check("single_valid", 76'(out_valid), 76'd1);
    drain("single_drain");

    // Three-record bundle drained back-to-back
    out_ready = 1'b1;
    send(1'b1, 12'h341, 64'd1, 1'b1, 12'h342, 64'd2, 1'b1, 2'd3);
    check("tri_level", 76'(out_level), 76'd3);
    check("tri_r0", out_rec, {12'h341, 64'd1});
    @(posedge clock); #1;
    check("tri_r1", out_rec, {12'h342, 64'd2});
    @(posedge clock); #1;
    check("tri_r2", out_rec, {12'hFFF, 64'd3});
    @(posedge clock); #1;
    check("tri_empty", 76'(out_valid), 76'd0);
    exp_q.delete();
    out_ready = 1'b0;

    // Fill until in_ready drops, stall, then drain
    send(1'b1, 12'h010, 64'd10, 1'b1, 12'h011, 64'd11, 1'b1, 2'd1);
    check("fill_lvl3",   76'(out_level), 76'd3);
    check("fill_rdy3",   76'(in_ready), 76'd1);
    send(1'b1, 12'h020, 64'd20, 1'b1, 12'h021, 64'd21, 1'b1, 2'd2);
    check("fill_lvl6",   76'(out_level), 76'd6);
    check("fill_rdy6",   76'(in_ready), 76'd0);
    in_valid = 1'b1;
    @(posedge clock); #1;
    check("stall_lvl",   76'(out_level), 76'd6);
    in_valid = 1'b0;
    check("stall_head",  out_rec, exp_q[0]);
    out_ready = 1'b1;
    @(posedge clock); #1;
    junk = exp_q.pop_front();
    check("rel_lvl5",    76'(out_level), 76'd5);
    check("rel_rdy5",    76'(in_ready), 76'd1);
    drain("fill_drain");

    // Same-id pair
    send(1'b1, 12'h180, 64'd5, 1'b1, 12'h180, 64'd7, 1'b0, 2'd0);
`ifdef CSR_UPDATE_DEDUP_EN
    check("dup_level", 76'(out_level), 76'd1);
    check("dup_rec",   out_rec, {12'h180, 64'd7});
`else
    check("dup_level", 76'(out_level), 76'd2);
    check("dup_rec",   out_rec, {12'h180, 64'd5});
`endif
    drain("dup_drain");

    // Wrap with random backpressure
    sent = 0;
    for (int cyc = 0; cyc < 400 && (sent < 20 || exp_q.size() > 0); cyc++) begin
      if (sent < 20 && in_ready) begin
        in_wen0 = 1'b1; in_wen1 = 1'b0; in_priv_wen = 1'b0;
        in_id0  = 12'(12'h100 + sent);
        in_val0 = 64'(sent + 1) * 64'h1111;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      acc     = in_valid && in_ready;
      pop_now = out_valid && out_ready;
      stall   = out_valid && !out_ready;
      held    = out_rec;
      if (pop_now) begin
        check("wrap_order", out_rec, exp_q[0]);
        junk = exp_q.pop_front();
      end
      @(posedge clock); #1;
      if (acc) begin
        exp_q.push_back({in_id0, in_val0});
        sent++;
      end
      if (stall) check("wrap_stable", out_rec, held);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("wrap_sent", 76'(sent), 76'd20);
    check("wrap_left", 76'(exp_q.size()), 76'd0);

    // Asynchronous reset with records pending
    send(1'b1, 12'h050, 64'd1, 1'b1, 12'h051, 64'd2, 1'b1, 2'd0);
    send(1'b1, 12'h052, 64'd3, 1'b0, 12'h0, 64'd0, 1'b0, 2'd0);
    check("pre_rst_lvl", 76'(out_level), 76'd4);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 76'(out_valid), 76'd0);
    check("arst_level", 76'(out_level), 76'd0);
    check("arst_rec",   out_rec, 76'd0);
    check("arst_ready", 76'(in_ready), 76'd1);
    exp_q.delete();
    #3 reset = 1'b0;
    send(1'b1, 12'h7AB, 64'h55, 1'b0, 12'h0, 64'd0, 1'b0, 2'd0);
    check("post_rst_rec", out_rec, {12'h7AB, 64'h55});
    drain("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
